phase_shift_mb: RTL

//  N-beam complex phase-shift/combine stage for the I/Q path ahead of the delta-sigma modulator.

---
 rtl/phase_shift_mb.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/phase_shift_mb.sv
`default_nettype none
// ============================================================================
//  Module   : phase_shift_mb
//  Purpose  : N-beam complex phase-shift/combine stage for the I/Q path ahead
//             of the delta-sigma modulator. One I/Q sample is captured every
//             DECIM clocks, rotated by one complex weight per beam through a
//             single shared complex multiplier, accumulated, then shifted,
//             saturated and emitted with a one-cycle strobe.
//             Beam weights are double-buffered: writes go to shadow registers
//             and a commit copies them to the active set on a capture edge.
//  Config   : PHASE_SHIFT_ROUND_EN - when defined and OUT_SHIFT>0, adds
//             2^(OUT_SHIFT-1) before the shift (round half up); otherwise the
//             shift truncates toward minus infinity.
//  Ports    : clock, reset        - clock, synchronous active-high reset
//             sysin_i/q           - signed I/Q input samples
//             wr_en/wr_beam       - shadow weight write strobe and beam index
//             wr_cos/wr_sin       - signed weight pair to write
//             commit              - request shadow->active copy
//             commit_pend         - commit requested, not yet applied
//             out_i/q             - signed saturated beam sum
//             out_valid           - one-cycle strobe, out_i/q just updated
//             out_sat             - {sat_q, sat_i} for the current output
//  Revision : 1.0 - initial release
// ============================================================================
module phase_shift_mb #(
  parameter int DATA_W    = 15,
  parameter int COEF_W    = 5,
  parameter int N_BEAMS   = 2,
  parameter int DECIM     = 8,
  parameter int OUT_SHIFT = 0
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic signed [DATA_W-1:0]                         sysin_i,
  input  logic signed [DATA_W-1:0]                         sysin_q,
  input  logic                                             wr_en,
  input  logic [((N_BEAMS > 1) ? $clog2(N_BEAMS) : 1)-1:0] wr_beam,
  input  logic signed [COEF_W-1:0]                         wr_cos,
  input  logic signed [COEF_W-1:0]                         wr_sin,
  input  logic                                             commit,
  output logic                                             commit_pend,
  output logic signed [DATA_W-1:0]                         out_i,
  output logic signed [DATA_W-1:0]                         out_q,
  output logic                                             out_valid,
  output logic [1:0]                                       out_sat
);

  localparam int c_beam_w = (N_BEAMS > 1) ? $clog2(N_BEAMS) : 1;
  localparam int c_acc_w  = DATA_W + COEF_W + 1 + $clog2(N_BEAMS);
  localparam int c_cnt_w  = $clog2(DECIM);

  localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(DECIM - 1);
  localparam logic [c_beam_w-1:0] c_beam_last = c_beam_w'(N_BEAMS - 1);

  // Saturation limits expressed at accumulator width; ~max is the matching minimum.
  localparam logic signed [c_acc_w-1:0] c_max = c_acc_w'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [c_acc_w-1:0] c_min = ~c_max;

`ifdef PHASE_SHIFT_ROUND_EN
  // (1<<OUT_SHIFT)>>1 is 2^(OUT_SHIFT-1) for OUT_SHIFT>0 and 0 for OUT_SHIFT=0.
  localparam logic signed [c_acc_w-1:0] c_round = (c_acc_w'(1) << OUT_SHIFT) >> 1;
`else
  localparam logic signed [c_acc_w-1:0] c_round = '0;
`endif

  // The whole accumulate pass must fit between two captures.
  generate
    if (N_BEAMS + 2 > DECIM) begin : g_param_check
      $error("phase_shift_mb: N_BEAMS+2 must be <= DECIM");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_acc_en;
  logic   w_last;

  logic [c_cnt_w-1:0]         r_dec_cnt;
  logic                       w_capture;
  logic                       w_wr_ok;
  logic [c_beam_w-1:0]        r_beam;
  logic signed [DATA_W-1:0]   r_in_i;
  logic signed [DATA_W-1:0]   r_in_q;
  logic signed [c_acc_w-1:0]  r_acc_i;
  logic signed [c_acc_w-1:0]  r_acc_q;
  logic                       r_commit_pend;
  logic signed [DATA_W-1:0]   r_out_i;
  logic signed [DATA_W-1:0]   r_out_q;
  logic                       r_out_valid;
  logic [1:0]                 r_out_sat;

  logic signed [COEF_W-1:0]   r_sh_cos  [N_BEAMS];
  logic signed [COEF_W-1:0]   r_sh_sin  [N_BEAMS];
  logic signed [COEF_W-1:0]   r_act_cos [N_BEAMS];
  logic signed [COEF_W-1:0]   r_act_sin [N_BEAMS];

  logic signed [c_acc_w-1:0]  w_ix, w_qx, w_cx, w_sx;
  logic signed [c_acc_w-1:0]  w_sum_i, w_sum_q;
  logic signed [c_acc_w-1:0]  w_sh_i, w_sh_q;
  logic                       w_hi_i, w_lo_i, w_hi_q, w_lo_q;
  logic signed [DATA_W-1:0]   w_sat_i, w_sat_q;

  assign w_capture = (r_dec_cnt == '0);
  assign w_wr_ok   = (int'(wr_beam) < N_BEAMS);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_en    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: if (w_capture) w_state_nxt = S_ACC;
      S_ACC: begin
        w_acc_en = 1'b1;
        w_last   = (r_beam == c_beam_last);
        if (w_last) w_state_nxt = S_OUT;
      end
      S_OUT:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ prescale counter
  always_ff @(posedge clock) begin
    if (reset)                        r_dec_cnt <= '0;
    else if (r_dec_cnt == c_cnt_last) r_dec_cnt <= '0;
    else                              r_dec_cnt <= r_dec_cnt + c_cnt_w'(1);
  end

  // A commit in the capture cycle must survive that capture, so the set wins.
  always_ff @(posedge clock) begin
    if (reset)          r_commit_pend <= 1'b0;
    else if (commit)    r_commit_pend <= 1'b1;
    else if (w_capture) r_commit_pend <= 1'b0;
  end

  // ------------------------------------------------------ weight registers
  // Non-blocking semantics give the required ordering: a swap in the same
  // cycle as a shadow write takes the pre-write shadow value.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int b = 0; b < N_BEAMS; b++) begin
        r_sh_cos[b]  <= '0;
        r_sh_sin[b]  <= '0;
        r_act_cos[b] <= '0;
        r_act_sin[b] <= '0;
      end
    end else begin
      if (wr_en && w_wr_ok) begin
        r_sh_cos[wr_beam] <= wr_cos;
        r_sh_sin[wr_beam] <= wr_sin;
      end
      if (w_capture && r_commit_pend) begin
        for (int b = 0; b < N_BEAMS; b++) begin
          r_act_cos[b] <= r_sh_cos[b];
          r_act_sin[b] <= r_sh_sin[b];
        end
      end
    end
  end

  // ------------------------------------------------------------ datapath
  // Operands are sign-extended to accumulator width so every product and
  // sum is exact.
  assign w_ix = c_acc_w'(r_in_i);
  assign w_qx = c_acc_w'(r_in_q);
  assign w_cx = c_acc_w'(r_act_cos[r_beam]);
  assign w_sx = c_acc_w'(r_act_sin[r_beam]);

  assign w_sum_i = r_acc_i + (w_ix * w_cx) + (w_qx * w_sx);
  assign w_sum_q = r_acc_q + (w_qx * w_cx) - (w_ix * w_sx);

  // Scaling works on the final sum (this beam included), so the result can be
  // registered on the last accumulate edge and out_valid lands in the OUT cycle.
  assign w_sh_i = (w_sum_i + c_round) >>> OUT_SHIFT;
  assign w_sh_q = (w_sum_q + c_round) >>> OUT_SHIFT;

  assign w_hi_i = (w_sh_i > c_max);
  assign w_lo_i = (w_sh_i < c_min);
  assign w_hi_q = (w_sh_q > c_max);
  assign w_lo_q = (w_sh_q < c_min);

  assign w_sat_i = w_hi_i ? c_max[DATA_W-1:0] : (w_lo_i ? c_min[DATA_W-1:0] : w_sh_i[DATA_W-1:0]);
  assign w_sat_q = w_hi_q ? c_max[DATA_W-1:0] : (w_lo_q ? c_min[DATA_W-1:0] : w_sh_q[DATA_W-1:0]);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_i      <= '0;
      r_in_q      <= '0;
      r_acc_i     <= '0;
      r_acc_q     <= '0;
      r_beam      <= '0;
      r_out_i     <= '0;
      r_out_q     <= '0;
      r_out_valid <= 1'b0;
      r_out_sat   <= 2'b00;
    end else begin
      r_out_valid <= 1'b0;
      if (w_capture) begin
        r_in_i  <= sysin_i;
        r_in_q  <= sysin_q;
        r_acc_i <= '0;
        r_acc_q <= '0;
        r_beam  <= '0;
      end else if (w_acc_en) begin
        r_acc_i <= w_sum_i;
        r_acc_q <= w_sum_q;
        r_beam  <= r_beam + c_beam_w'(1);
        if (w_last) begin
          r_out_i     <= w_sat_i;
          r_out_q     <= w_sat_q;
          r_out_sat   <= {(w_hi_q | w_lo_q), (w_hi_i | w_lo_i)};
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign commit_pend = r_commit_pend;
  assign out_i       = r_out_i;
  assign out_q       = r_out_q;
  assign out_valid   = r_out_valid;
  assign out_sat     = r_out_sat;

endmodule
`default_nettype wire
